// File: rtl/poly1305_mulred_arbiter.sv
// Round-robin arbiter sharing one Poly1305 multiply/reduce unit pair between two requesters.
// Latches operands, sequences the start/done handshakes and aborts on a per-phase watchdog.
module poly1305_mulred_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [129:0] req0_a,
    input  logic [127:0] req0_b,
    output logic         req0_ready,
    output logic         rsp0_valid,
    output logic         rsp0_err,
    input  logic         req1_valid,
    input  logic [129:0] req1_a,
    input  logic [127:0] req1_b,
    output logic         req1_ready,
    output logic         rsp1_valid,
    output logic         rsp1_err,
    output logic [129:0] rsp_data,
    output logic         mul_start,
    output logic [129:0] mul_a,
    output logic [127:0] mul_b,
    input  logic [257:0] mul_product,
    input  logic         mul_done,
    output logic         red_start,
    output logic [257:0] red_value,
    input  logic [129:0] red_out,
    input  logic         red_done,
    output logic         busy,
    output logic [15:0]  op_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE_MUL = 3'd1,
        WAIT_MUL  = 3'd2,
        ISSUE_RED = 3'd3,
        WAIT_RED  = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         owner_q, owner_d;
    logic [129:0] mul_a_q, mul_a_d;
    logic [127:0] mul_b_q, mul_b_d;
    logic [257:0] red_value_q, red_value_d;
    logic [129:0] rsp_data_q, rsp_data_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  op_count_q, op_count_d;
    logic         mul_start_q, mul_start_d;
    logic         red_start_q, red_start_d;
    logic         rsp0_valid_q, rsp0_valid_d;
    logic         rsp1_valid_q, rsp1_valid_d;
    logic         rsp0_err_q, rsp0_err_d;
    logic         rsp1_err_q, rsp1_err_d;
    logic         grant0, grant1;
    logic         timeout;

    // The pointer only breaks ties; a lone valid requester always wins.
    assign grant1 = req1_valid && (!req0_valid || ptr_q);
    assign grant0 = req0_valid && !grant1;

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req0_ready = (state_q == IDLE) && grant0 && !rst;
    assign req1_ready = (state_q == IDLE) && grant1 && !rst;
    assign timeout    = (cnt_q == TIMEOUT_LAST);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        red_value_d = red_value_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        op_count_d  = op_count_q;
        rsp0_err_d  = 1'b0;
        rsp1_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ISSUE_MUL;
                    owner_d = grant1;
                    ptr_d   = !grant1;
                    mul_a_d = grant1 ? req1_a : req0_a;
                    mul_b_d = grant1 ? req1_b : req0_b;
                    cnt_d   = '0;
                end
            end
            ISSUE_MUL: begin
                state_d = WAIT_MUL;
                cnt_d   = '0;
            end
            WAIT_MUL: begin
                // A done on the final watchdog cycle still wins over the abort.
                if (mul_done) begin
                    state_d     = ISSUE_RED;
                    red_value_d = mul_product;
                end else if (timeout) begin
                    state_d    = IDLE;
                    rsp0_err_d = !owner_q;
                    rsp1_err_d = owner_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ISSUE_RED: begin
                state_d = WAIT_RED;
                cnt_d   = '0;
            end
            WAIT_RED: begin
                if (red_done) begin
                    state_d    = RESP;
                    rsp_data_d = red_out;
                end else if (timeout) begin
                    state_d    = IDLE;
                    rsp0_err_d = !owner_q;
                    rsp1_err_d = owner_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        mul_start_d  = (state_d == ISSUE_MUL);
        red_start_d  = (state_d == ISSUE_RED);
        rsp0_valid_d = (state_d == RESP) && !owner_d;
        rsp1_valid_d = (state_d == RESP) && owner_d;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            red_value_q  <= '0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
            op_count_q   <= '0;
            mul_start_q  <= 1'b0;
            red_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            red_value_q  <= red_value_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
            op_count_q   <= op_count_d;
            mul_start_q  <= mul_start_d;
            red_start_q  <= red_start_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign red_start  = red_start_q;
    assign red_value  = red_value_q;
    assign rsp_data   = rsp_data_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_poly1305_mulred_arbiter.sv
// Bench for poly1305_mulred_arbiter: stub multiplier/reducer, response scoreboard,
// a vector table plus hand-written latency, arbitration, timeout and reset sequences.
module tb_poly1305_mulred_arbiter;

    localparam int TO = 8;
    localparam logic [257:0] P = (258'd1 << 130) - 258'd5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [129:0] req0_a, req1_a;
    logic [127:0] req0_b, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [129:0] rsp_data;
    logic         mul_start, mul_done, red_start, red_done, busy;
    logic [129:0] mul_a, red_out;
    logic [127:0] mul_b;
    logic [257:0] mul_product, red_value;
    logic [15:0]  op_count;

    poly1305_mulred_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
        .rsp_data(rsp_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
        .red_start(red_start), .red_value(red_value), .red_out(red_out), .red_done(red_done),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [129:0] model(input logic [129:0] a, input logic [127:0] b);
        logic [257:0] prod;
        prod = 258'(a) * 258'(b);
        return 130'(prod % P);
    endfunction

    typedef struct {
        bit           owner;
        bit           err;
        logic [129:0] data;
    } exp_t;
    exp_t sb[$];
    int   grants[$];

    typedef struct {
        bit           owner;
        logic [129:0] a;
        logic [127:0] b;
        int           mul_lat;
        int           red_lat;
        bit           spur;
    } vec_t;
    vec_t vecs[6];

    // Stub units: latencies counted from the sampled start pulse; latency 0 means never done.
    int mul_lat = 3, red_lat = 2;
    bit spurious = 0;
    int mcnt = 0, rcnt = 0, sm = 0, sr = 0;
    int mstart_cyc = 0, rstart_cyc = 0, rsp_cyc = 0, err_cyc = 0, rsp_seen = 0;
    logic err_busy = 1'b1;
    logic [129:0] last_rsp_data = '0;

    initial begin
        mul_done = 1'b0; red_done = 1'b0; mul_product = '0; red_out = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            red_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin mul_done = 1'b1; mul_product = 258'(mul_a) * 258'(mul_b); end
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin red_done = 1'b1; red_out = 130'(red_value % P); end
            end
            if (sr > 0) begin
                sr--;
                if (sr == 0) begin red_done = 1'b1; red_out = '1; end
            end
            if (sm > 0) begin
                sm--;
                if (sm == 0) begin mul_done = 1'b1; mul_product = '1; end
            end
            if (mul_start) begin mstart_cyc = cyc; mcnt = mul_lat; if (spurious) sr = 1; end
            if (red_start) begin rstart_cyc = cyc; rcnt = red_lat; if (spurious) sm = 1; end
        end
    end

    // Response monitor: every pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (rsp0_valid || rsp1_valid || rsp0_err || rsp1_err)) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {rsp1_err, rsp0_err, rsp1_valid, rsp0_valid}, 4'b0000);
                end else begin
                    e = sb.pop_front();
                    if (e.err) begin
                        err_cyc  = cyc;
                        err_busy = busy;
                        check("err_flags", {rsp1_err, rsp0_err, rsp1_valid, rsp0_valid},
                              e.owner ? 4'b1000 : 4'b0100);
                    end else begin
                        rsp_cyc       = cyc;
                        last_rsp_data = rsp_data;
                        check("rsp_flags", {rsp1_err, rsp0_err, rsp1_valid, rsp0_valid},
                              e.owner ? 4'b0010 : 4'b0001);
                        check("rsp_data", rsp_data, e.data);
                    end
                end
            end
        end
    end

    int accept_cyc = 0;
    int last_wait = 0;

    task automatic do_req(input bit owner, input logic [129:0] a, input logic [127:0] b, input bit exp_err);
        int  n;
        bit  rdy;
        exp_t e;
        n = 0;
        @(negedge clk);
        if (owner) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else       begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1 rdy = owner ? req1_ready : req0_ready;
        while (!rdy && n < 200) begin
            @(negedge clk);
            #1 rdy = owner ? req1_ready : req0_ready;
            n++;
        end
        last_wait = n;
        if (!rdy) begin
            check("req_accept_timeout", 1'b0, 1'b1);
        end else begin
            accept_cyc = cyc;
            grants.push_back(int'(owner));
            e.owner = owner; e.err = exp_err; e.data = model(a, b);
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        if (owner) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", (sb.size() == 0 && !busy), 1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_ops;
        int seen;
        int exp_order[4];
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        vecs[0] = '{1'b0, {130{1'b1}}, {128{1'b1}}, 3, 2, 1'b0};
        vecs[1] = '{1'b1, 130'h0, 128'h1234, 1, 1, 1'b0};
        vecs[2] = '{1'b0, 130'(P - 258'd1), 128'h2, 8, 8, 1'b0};
        vecs[3] = '{1'b1, 130'h2_0000_0000_0000_0000_0000_0000_0000_0000, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 2, 3, 1'b1};
        vecs[4] = '{1'b0, 130'h1_2345_6789_abcd_ef01_2345_6789_abcd_ef01, 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff, 3, 2, 1'b1};
        vecs[5] = '{1'b1, 130'h5, 128'h1, 4, 4, 1'b0};
        exp_order = '{0, 1, 0, 1};

        // Reset values, with a request pending to show ready stays low.
        repeat (2) @(negedge clk);
        req0_valid = 1'b1; req0_a = 130'h7; req0_b = 128'h9;
        #1;
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_ctl", {busy, mul_start, red_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 7'b0);
        check("rst_data", |{mul_a, mul_b, red_value, rsp_data}, 1'b0);
        check("rst_op_count", op_count, 16'd0);
        req0_valid = 1'b0;
        @(negedge clk) rst = 1'b0;

        // Single op latency: mul_done 3 after start, red_done 2 after start.
        do_req(1'b0, 130'h1, 128'h2, 1'b0);
        wait_idle();
        check("lat_mul_start", mstart_cyc - accept_cyc, 1);
        check("lat_red_start", rstart_cyc - accept_cyc, 5);
        check("lat_rsp", rsp_cyc - accept_cyc, 8);
        check("lat_rsp_data", last_rsp_data, 130'h2);
        check("lat_op_count", op_count, 16'd1);

        // Vector table: operand extremes, done on the last watchdog cycle, spurious dones.
        for (int i = 0; i < 6; i++) begin
            mul_lat  = vecs[i].mul_lat;
            red_lat  = vecs[i].red_lat;
            spurious = vecs[i].spur;
            do_req(vecs[i].owner, vecs[i].a, vecs[i].b, 1'b0);
            wait_idle();
        end
        spurious = 0; mul_lat = 3; red_lat = 2;
        check("table_op_count", op_count, 16'd7);

        // Lone requester 1 for three ops: accepted immediately every time.
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 130'(i + 11), 128'(3 * i + 7), 1'b0);
            check("req1_no_stall", last_wait, 0);
            wait_idle();
        end
        check("req1_op_count", op_count, 16'd10);

        // Watchdog: multiplier never finishes.
        base_ops = int'(op_count);
        mul_lat = 0;
        do_req(1'b0, 130'h33, 128'h44, 1'b1);
        wait_idle();
        check("to_err_cycle", err_cyc - accept_cyc, 10);
        check("to_busy_low", err_busy, 1'b0);
        check("to_op_count", op_count, 16'(base_ops));
        mul_lat = 3;
        do_req(1'b0, 130'h55, 128'h66, 1'b0);
        wait_idle();
        check("post_to_op_count", op_count, 16'(base_ops + 1));

        // Reset during WAIT_RED with the pointer left favouring requester 1.
        do_req(1'b0, 130'h77, 128'h88, 1'b0);
        begin
            int n;
            n = 0;
            while (!red_start && n < 50) begin @(negedge clk); n++; end
            check("reach_issue_red", red_start, 1'b1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_ctl", {busy, mul_start, red_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready}, 9'b0);
        check("rstmid_data", |{mul_a, mul_b, red_value, rsp_data}, 1'b0);
        check("rstmid_op_count", op_count, 16'd0);
        sb.delete();
        seen = rsp_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rstmid_no_rsp", rsp_seen - seen, 0);

        // Both requesters held from reset: grants alternate 0,1,0,1.
        grants.delete();
        fork
            begin
                do_req(1'b0, 130'h101, 128'h202, 1'b0);
                do_req(1'b0, 130'h303, 128'h404, 1'b0);
            end
            begin
                do_req(1'b1, 130'h505, 128'h606, 1'b0);
                do_req(1'b1, 130'h707, 128'h808, 1'b0);
            end
        join
        wait_idle();
        check("rr_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check($sformatf("rr_grant%0d", i), grants[i], exp_order[i]);
        end
        check("rr_op_count", op_count, 16'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
